// File: rtl/ahb_uart_tx_slave_pkg.sv
// Shared register map, bit positions and transmitter state encodings for the
// AHB UART transmit slave and its bench.
package ahb_uart_tx_slave_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;
  localparam logic [31:0] OFF_RSVD   = 32'h0000_000C;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_LVL_LSB = 4;
  localparam int unsigned CTRL_EN      = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Packed so that en lands on bit 16 when zero-extended onto the bus.
  typedef struct packed {
    logic        en;
    logic [15:0] prescale;
  } ctrl_t;

endpackage

// File: rtl/ahb_uart_tx_slave_if.sv
// AHB-Lite slave-side signal bundle; clock and reset stay as plain ports.
interface ahb_uart_tx_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_uart_tx_slave_sync_fifo.sv
// Synchronous FIFO with show-ahead read data; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + (AW+1)'(1);
      else if (do_pop && !do_push) level_q <= level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/ahb_uart_tx_slave.sv
// AHB-Lite slave feeding an 8N1 UART transmitter through a byte FIFO;
// zero wait state, 16 baud ticks per bit.
module ahb_uart_tx_slave
  import ahb_uart_tx_slave_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [15:0] PRESCALE_RST = 16'd51
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  ahb_uart_tx_slave_if.slave        bus,
  output logic                      TX,
  output logic                      IRQ
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          dp_valid_q, dp_write_q;
  logic [1:0]    dp_addr_q;
  ctrl_t         ctrl_q, ctrl_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic          tick;
  logic [1:0]    state_q, state_d;
  logic [3:0]    sub_q, sub_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0]    fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic          wr_data, wr_status, wr_ctrl;
  logic [31:0]   status_w;
  logic          unused_bits;

  assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA[31:17]};

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
    end else begin
      dp_valid_q <= bus.HSEL & bus.HTRANS[1] & bus.HREADY;
      dp_write_q <= bus.HWRITE;
      dp_addr_q  <= bus.HADDR[3:2];
    end
  end

  assign wr_data   = dp_valid_q & dp_write_q & (dp_addr_q == REG_DATA);
  assign wr_status = dp_valid_q & dp_write_q & (dp_addr_q == REG_STATUS);
  assign wr_ctrl   = dp_valid_q & dp_write_q & (dp_addr_q == REG_CTRL);

  assign fifo_pop  = (state_q == ST_IDLE) & ctrl_q.en & ~fifo_empty;
  assign fifo_push = wr_data & (~fifo_full | fifo_pop);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .push_i  (fifo_push),
    .wdata_i (bus.HWDATA[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Overflow set is applied last so it beats a clear in the same cycle.
  always_comb begin
    ovf_d  = ovf_q;
    ctrl_d = ctrl_q;
    if (wr_status && bus.HWDATA[STAT_OVF]) ovf_d = 1'b0;
    if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (wr_ctrl) ctrl_d = '{en: bus.HWDATA[CTRL_EN], prescale: bus.HWDATA[15:0]};
  end

  // >= makes a prescale reduced below the running count wrap immediately.
  assign tick = ctrl_q.en & (baud_cnt_q >= ctrl_q.prescale);

  always_comb begin
    baud_cnt_d = '0;
    if (ctrl_q.en && !tick) baud_cnt_d = baud_cnt_q + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (tick && state_q != ST_IDLE) sub_d = sub_q + 4'd1;
    case (state_q)
      ST_IDLE: if (fifo_pop) begin
        state_d = ST_START;
        sub_d   = '0;
        bit_d   = '0;
        shift_d = fifo_rdata;
      end
      ST_START: if (tick && sub_q == 4'hF) state_d = ST_DATA;
      ST_DATA: if (tick && sub_q == 4'hF) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = ST_STOP;
      end
      default: if (tick && sub_q == 4'hF) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ctrl_q     <= '{en: 1'b0, prescale: PRESCALE_RST};
      ovf_q      <= 1'b0;
      baud_cnt_q <= '0;
      state_q    <= ST_IDLE;
      sub_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      baud_cnt_q <= baud_cnt_d;
      state_q    <= state_d;
      sub_q      <= sub_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
    end
  end

  assign TX  = (state_q == ST_START) ? 1'b0 :
               (state_q == ST_DATA)  ? shift_q[0] : 1'b1;
  assign IRQ = fifo_empty & (state_q == ST_IDLE);

  always_comb begin
    status_w                         = '0;
    status_w[STAT_FULL]              = fifo_full;
    status_w[STAT_EMPTY]             = fifo_empty;
    status_w[STAT_BUSY]              = (state_q != ST_IDLE);
    status_w[STAT_OVF]               = ovf_q;
    status_w[STAT_LVL_LSB +: LW]     = fifo_level;
    bus.HRDATA = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        REG_STATUS: bus.HRDATA = status_w;
        REG_CTRL:   bus.HRDATA = {15'd0, ctrl_q};
        default:    bus.HRDATA = '0;
      endcase
    end
  end
endmodule
